// File: rtl/gate_sequencer_pkg.sv
// Shared types and default constants for the gate sequencer.
// The FSM state enum uses an explicit 3-bit encoding.
package gate_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARMED   = 3'd1,
    ST_GATE    = 3'd2,
    ST_DONE    = 3'd3,
    ST_HOLDOFF = 3'd4
  } state_e;

  localparam int DEF_CNT_W       = 32;
  localparam int DEF_HOLDOFF_CYC = 16;
  localparam int DEF_TIMEOUT_CYC = 1048576;

  // Width of a down-counter that must hold values 0 .. cyc-1 (at least 1 bit).
  function automatic int hold_w(input int cyc);
    return (cyc > 1) ? $clog2(cyc) : 1;
  endfunction

endpackage

// File: rtl/edge_detect.sv
// Trigger conditioning: two-stage synchronizer plus one history stage.
// The three flops carry no reset; the FSM sits in IDLE after reset, so any
// spurious edge produced while they flush is harmless.
module edge_detect (
  input  logic clk,
  input  logic din,
  output logic pos_edge,
  output logic neg_edge
);

  logic sync1_q;
  logic sync2_q;
  logic prev_q;

  // Synchronize the raw input and keep one cycle of history.
  always_ff @(posedge clk) begin
    sync1_q <= din;
    sync2_q <= sync1_q;
    prev_q  <= sync2_q;
  end

  // Both edges compare the same two flops, so they can never fire together.
  assign pos_edge = sync2_q & ~prev_q;
  assign neg_edge = ~sync2_q & prev_q;

endmodule

// File: rtl/gate_sequencer.sv
// Gate sequencer: arms on request, opens a counting gate between trigger
// edges, reports the gate length, then waits a dead time before re-arming.
// Optional build macro GATE_TIMEOUT_EN closes the gate after TIMEOUT_CYC
// cycles and flags the result as a timeout.
module gate_sequencer
  import gate_sequencer_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int HOLDOFF_CYC = DEF_HOLDOFF_CYC,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             trig,
  input  logic             arm,
  input  logic             abort,
  input  logic             res_ready,
  output logic             gate,
  output logic             busy,
  output logic             res_valid,
  output logic [CNT_W-1:0] res_len,
  output logic             res_tmo,
  output logic             overrun
);

  localparam int                HW        = hold_w(HOLDOFF_CYC);
  localparam logic [HW-1:0]     HOLD_INIT = HW'((HOLDOFF_CYC > 0) ? HOLDOFF_CYC - 1 : 0);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  logic pos_edge;
  logic neg_edge;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
  logic [HW-1:0]     hcnt_q, hcnt_d;
  logic              ovr_q, ovr_d;
  logic              gate_q, busy_q, valid_q;

  edge_detect u_edge (
    .clk      (clk),
    .din      (trig),
    .pos_edge (pos_edge),
    .neg_edge (neg_edge)
  );

`ifdef GATE_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TMO_VAL = CNT_W'(TIMEOUT_CYC);
  logic tmo_q, tmo_d;
`else
  // Keeps the timeout parameter referenced when the feature is compiled out.
  logic unused_tmo;
  assign unused_tmo = ^TIMEOUT_CYC;
`endif

  // Next-state, counter and sticky-flag logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hcnt_d  = hcnt_q;
    ovr_d   = ovr_q | (arm && (state_q != ST_IDLE));
    cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
`ifdef GATE_TIMEOUT_EN
    tmo_d   = tmo_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (arm) begin
          state_d = ST_ARMED;
          cnt_d   = '0;
`ifdef GATE_TIMEOUT_EN
          tmo_d   = 1'b0;
`endif
        end
      end
      ST_ARMED: begin
        if (abort)         state_d = ST_IDLE;
        else if (pos_edge) state_d = ST_GATE;
      end
      ST_GATE: begin
        // Abort beats a same-cycle falling edge; no result is produced.
        if (abort) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_inc;
`ifdef GATE_TIMEOUT_EN
          if (cnt_inc == TMO_VAL) begin
            state_d = ST_DONE;
            tmo_d   = 1'b1;
          end else
`endif
          if (neg_edge) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (res_ready) begin
          if (HOLDOFF_CYC == 0) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_HOLDOFF;
            hcnt_d  = HOLD_INIT;
          end
        end
      end
      ST_HOLDOFF: begin
        if (hcnt_q == '0) state_d = ST_IDLE;
        else              hcnt_d  = hcnt_q - 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register; status outputs are decoded from the next state so they
  // line up with the registered state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      hcnt_q  <= '0;
      ovr_q   <= 1'b0;
      gate_q  <= 1'b0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
`ifdef GATE_TIMEOUT_EN
      tmo_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hcnt_q  <= hcnt_d;
      ovr_q   <= ovr_d;
      gate_q  <= (state_d == ST_GATE);
      busy_q  <= (state_d != ST_IDLE);
      valid_q <= (state_d == ST_DONE);
`ifdef GATE_TIMEOUT_EN
      tmo_q   <= tmo_d;
`endif
    end
  end

  assign gate      = gate_q;
  assign busy      = busy_q;
  assign res_valid = valid_q;
  assign res_len   = cnt_q;
  assign overrun   = ovr_q;
`ifdef GATE_TIMEOUT_EN
  assign res_tmo   = tmo_q;
`else
  assign res_tmo   = 1'b0;
`endif

endmodule
